voice_sample_player: RTL and testbench

//  Consumes the 16-bit PCM sample FIFO of the SD feed stage and turns it into a

---
 rtl/voice_sample_player.sv | 144 ++++++++++++++
 tb/tb_voice_sample_player.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/voice_sample_player.sv
// Voice sample player: reads one PCM word per audio tick from the SD feed FIFO,
// scales it by note velocity and applies a linear release ramp.
module voice_sample_player #(
    parameter int CLK_DIV     = 2000,
    parameter int PRIME_TICKS = 4,
    parameter int REL_STEP    = 1
) (
    input  logic        clk96m,
    input  logic        rst,
    input  logic        note_on,
    input  logic        note_off,
    input  logic [6:0]  velocity,
    input  logic        stream_done,
    output logic        fifo_rd_en,
    input  logic [15:0] fifo_data,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    output logic        active
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int PW = $clog2(PRIME_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_PLAY,
        S_REL
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] prime_q;
    logic [7:0]    gain_q;
    logic [7:0]    mgain_q;
    logic          t1_q;
    logic          t2_q;
    logic          rd_q;
    logic          rd2_q;
    logic          valid_q;
    logic          active_q;
    logic [15:0]   sample_q;

    logic               tick;
    logic               playing;
    logic [7:0]         vel_gain;
    logic signed [24:0] data_x;
    logic signed [24:0] gain_x;
    logic signed [24:0] prod;
    logic               unused_prod;

    assign tick     = (cnt_q == CW'(CLK_DIV - 1));
    assign playing  = (state_q == S_PLAY) || (state_q == S_REL);
    assign vel_gain = {1'b0, velocity} + {7'd0, velocity[6]};

    // Product always fits: |data| <= 2^15, gain <= 128, so bits 22:7 hold the floor shift.
    assign data_x      = 25'($signed(fifo_data));
    assign gain_x      = 25'({1'b0, mgain_q});
    assign prod        = data_x * gain_x;
    assign unused_prod = ^{prod[24:23], prod[6:0]};

    always_ff @(posedge clk96m) begin
        if (rst) begin
            cnt_q    <= '0;
            t1_q     <= 1'b0;
            t2_q     <= 1'b0;
            rd_q     <= 1'b0;
            rd2_q    <= 1'b0;
            valid_q  <= 1'b0;
            mgain_q  <= '0;
            sample_q <= '0;
        end else begin
            cnt_q    <= tick ? '0 : cnt_q + CW'(1);
            t1_q     <= tick;
            t2_q     <= t1_q;
            valid_q  <= t2_q;
            rd_q     <= tick && playing;
            rd2_q    <= rd_q;
            if (rd_q)
                mgain_q <= gain_q;
            sample_q <= rd2_q ? prod[22:7] : '0;
        end
    end

    always_ff @(posedge clk96m) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gain_q   <= '0;
            prime_q  <= '0;
            active_q <= 1'b0;
        end else if (note_on) begin
            state_q  <= S_PRIME;
            gain_q   <= vel_gain;
            prime_q  <= PW'(PRIME_TICKS);
            active_q <= 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_PRIME: begin
                    if (note_off) begin
                        state_q  <= S_IDLE;
                        gain_q   <= '0;
                        active_q <= 1'b0;
                    end else if (tick) begin
                        prime_q <= prime_q - PW'(1);
                        if (prime_q == PW'(1))
                            state_q <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (stream_done) begin
                        state_q  <= S_IDLE;
                        gain_q   <= '0;
                        active_q <= 1'b0;
                    end else if (note_off) begin
                        state_q <= S_REL;
                    end
                end
                S_REL: begin
                    if (stream_done) begin
                        state_q  <= S_IDLE;
                        gain_q   <= '0;
                        active_q <= 1'b0;
                    end else if (tick) begin
                        if (gain_q <= 8'(REL_STEP)) begin
                            state_q  <= S_IDLE;
                            gain_q   <= '0;
                            active_q <= 1'b0;
                        end else begin
                            gain_q <= gain_q - 8'(REL_STEP);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fifo_rd_en   = rd_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign active       = active_q;

endmodule

// File: tb/tb_voice_sample_player.sv
// Directed bench for voice_sample_player: tick-aligned read/output timing,
// velocity scaling, release ramp, retrigger and mid-stream reset.
module tb_voice_sample_player;

    localparam int DIV = 100;

    logic        clk96m = 1'b0;
    logic        rst = 1'b1;
    logic        note_on = 1'b0;
    logic        note_off = 1'b0;
    logic        stream_done = 1'b0;
    logic [6:0]  velocity = '0;
    logic [15:0] fifo_data = 16'hA5A5;
    logic        fifo_rd_en;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        active;

    int ph = 0;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk96m = ~clk96m;

    voice_sample_player #(
        .CLK_DIV(DIV),
        .PRIME_TICKS(4),
        .REL_STEP(1)
    ) dut (
        .clk96m(clk96m),
        .rst(rst),
        .note_on(note_on),
        .note_off(note_off),
        .velocity(velocity),
        .stream_done(stream_done),
        .fifo_rd_en(fifo_rd_en),
        .fifo_data(fifo_data),
        .sample_out(sample_out),
        .sample_valid(sample_valid),
        .active(active)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk96m);
        #1;
        ph = (ph + 1) % DIV;
    endtask

    task automatic pulse(input logic on, input logic off, input logic done,
                         input logic [6:0] vel);
        note_on = on;
        note_off = off;
        stream_done = done;
        velocity = vel;
        step();
        note_on = 1'b0;
        note_off = 1'b0;
        stream_done = 1'b0;
    endtask

    // Walks to the next tick T and checks T+1 read, T+3 output, and silence elsewhere.
    task automatic run_tick(input string tag, input logic exp_rd,
                            input logic [15:0] word, input logic [15:0] exp_out);
        logic stray;
        stray = 1'b0;
        while (ph != DIV - 1) begin
            step();
            stray |= fifo_rd_en | sample_valid;
        end
        step();
        check({tag, "/rd"}, fifo_rd_en, exp_rd);
        stray |= sample_valid;
        step();
        fifo_data = exp_rd ? word : 16'hA5A5;
        stray |= fifo_rd_en | sample_valid;
        step();
        fifo_data = 16'hA5A5;
        check({tag, "/valid"}, sample_valid, 1'b1);
        check({tag, "/out"}, sample_out, exp_out);
        stray |= fifo_rd_en;
        check({tag, "/quiet"}, stray, 1'b0);
    endtask

    task automatic prime(input string tag);
        repeat (4) run_tick(tag, 1'b0, 16'h1111, 16'h0000);
    endtask

    initial begin
        step();
        step();
        check("reset", {fifo_rd_en, sample_valid, active, sample_out}, 0);
        rst = 1'b0;
        ph = 0;

        repeat (3) run_tick("t1_idle", 1'b0, 16'h0000, 16'h0000);

        pulse(1'b1, 1'b0, 1'b0, 7'd127);
        check("t2_active", active, 1'b1);
        prime("t2_prime");
        run_tick("t2_a", 1'b1, 16'h4000, 16'h4000);
        run_tick("t2_b", 1'b1, 16'hC000, 16'hC000);

        // velocity 64 has bit 6 set, so gain is 65
        pulse(1'b1, 1'b0, 1'b0, 7'd64);
        prime("t3_prime");
        run_tick("t3_pos", 1'b1, 16'h7FFF, 16'h40FF);
        run_tick("t3_neg", 1'b1, 16'h8001, 16'hBF00);

        pulse(1'b1, 1'b0, 1'b0, 7'd3);
        prime("t4_prime");
        run_tick("t4_g3", 1'b1, 16'h4000, 16'h0180);
        pulse(1'b0, 1'b1, 1'b0, 7'd0);
        check("t4_rel_active", active, 1'b1);
        run_tick("t4_g2", 1'b1, 16'h4000, 16'h0100);
        run_tick("t4_g1", 1'b1, 16'hC000, 16'hFF80);
        check("t4_g1_active", active, 1'b1);
        run_tick("t4_g0", 1'b1, 16'h7FFF, 16'h0000);
        check("t4_idle_active", active, 1'b0);
        run_tick("t4_idle", 1'b0, 16'h0000, 16'h0000);

        pulse(1'b1, 1'b0, 1'b0, 7'd127);
        pulse(1'b0, 1'b1, 1'b0, 7'd0);
        check("prime_off_active", active, 1'b0);
        run_tick("prime_off_idle", 1'b0, 16'h0000, 16'h0000);

        pulse(1'b1, 1'b0, 1'b0, 7'd127);
        prime("t5_prime");
        run_tick("t5_play", 1'b1, 16'hC000, 16'hC000);
        pulse(1'b1, 1'b0, 1'b1, 7'd10);
        check("t5_retrig_active", active, 1'b1);
        run_tick("t5_prime", 1'b0, 16'h1111, 16'h0000);
        pulse(1'b0, 1'b0, 1'b1, 7'd0);
        check("t5_done_in_prime", active, 1'b1);
        repeat (3) run_tick("t5_prime", 1'b0, 16'h1111, 16'h0000);
        run_tick("t5_g10", 1'b1, 16'h4000, 16'h0500);
        pulse(1'b0, 1'b0, 1'b1, 7'd0);
        check("t5_done_active", active, 1'b0);
        run_tick("t5_idle", 1'b0, 16'h0000, 16'h0000);

        pulse(1'b1, 1'b0, 1'b0, 7'd127);
        prime("t6_prime");
        run_tick("t6_play", 1'b1, 16'h2000, 16'h2000);
        while (ph != DIV - 1) step();
        step();
        check("t6_rd", fifo_rd_en, 1'b1);
        rst = 1'b1;
        step();
        check("t6_rst", {fifo_rd_en, sample_valid, active, sample_out}, 0);
        rst = 1'b0;
        ph = 0;
        step();
        check("t6_novalid", sample_valid, 1'b0);
        repeat (2) run_tick("t6_idle", 1'b0, 16'h0000, 16'h0000);
        pulse(1'b1, 1'b0, 1'b0, 7'd127);
        prime("t6_prime2");
        run_tick("t6_again", 1'b1, 16'h1234, 16'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
